// File: rtl/matrix_mac_engine.sv
// NxN unsigned matrix multiply-accumulate engine: element-serial load of A and B,
// one sequential MAC computing C = A*B or C += A*B, registered random-access result read.
module matrix_mac_engine #(
    parameter int N  = 2,
    parameter int DW = 2,
    parameter int CW = 8,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          load_done,
    input  logic          start,
    input  logic          accumulate,
    input  logic          clear,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    input  logic [AW-1:0] rd_row,
    input  logic [AW-1:0] rd_col,
    output logic [CW-1:0] rd_data
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_COMPUTE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t state;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];
    logic [CW-1:0] c_mem [N][N];

    // Load position: ld_sel = 0 while filling A, 1 while filling B.
    logic [AW-1:0] ld_row;
    logic [AW-1:0] ld_col;
    logic          ld_sel;

    logic [AW-1:0] ci;
    logic [AW-1:0] cj;
    logic [AW-1:0] ck;
    logic          acc_mode;
    logic [CW-1:0] acc;

    logic [2*DW-1:0] mac_prod;
    logic [CW-1:0]   mac_seed;
    logic [CW:0]     mac_sum;
    logic            load_fire;
    logic            load_last;
    logic            mac_write;
    logic            mac_last;
    logic            c_clear;
    logic            rd_in_range;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults or full if/else) so no latch is inferred.
    always_comb begin
        mac_prod = (2*DW)'(a_mem[ci][ck]) * (2*DW)'(b_mem[ck][cj]);
        if (ck == '0) begin
            mac_seed = acc_mode ? c_mem[ci][cj] : '0;
        end else begin
            mac_seed = acc;
        end
        mac_sum     = {1'b0, mac_seed} + (CW+1)'(mac_prod);
        load_fire   = (state == ST_LOAD) && in_valid && in_ready;
        load_last   = ld_sel && (ld_row == LAST) && (ld_col == LAST);
        mac_write   = (state == ST_COMPUTE) && (ck == LAST);
        mac_last    = mac_write && (ci == LAST) && (cj == LAST);
        c_clear     = clear && (state != ST_COMPUTE);
        rd_in_range = ({1'b0, rd_row} < (AW+1)'(N)) && ({1'b0, rd_col} < (AW+1)'(N));
    end

    // Control FSM: state, load position, loop indices and the registered status outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            in_ready  <= 1'b0;
            load_done <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ld_row    <= '0;
            ld_col    <= '0;
            ld_sel    <= 1'b0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            acc_mode  <= 1'b0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (load_fire) begin
                        if (ld_col == LAST) begin
                            ld_col <= '0;
                            if (ld_row == LAST) begin
                                ld_row <= '0;
                                ld_sel <= ~ld_sel;
                            end else begin
                                ld_row <= ld_row + 1'b1;
                            end
                        end else begin
                            ld_col <= ld_col + 1'b1;
                        end
                        if (load_last) begin
                            state     <= ST_READY;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end

                ST_READY: begin
                    // clear takes priority; a coincident start is dropped.
                    if (start && !clear) begin
                        state     <= ST_COMPUTE;
                        busy      <= 1'b1;
                        load_done <= 1'b0;
                        acc_mode  <= accumulate;
                        ci        <= '0;
                        cj        <= '0;
                        ck        <= '0;
                    end
                end

                ST_COMPUTE: begin
                    acc <= mac_sum[CW-1:0];
                    if (ck == LAST) begin
                        ck <= '0;
                        if (cj == LAST) begin
                            cj <= '0;
                            if (ci == LAST) begin
                                ci <= '0;
                            end else begin
                                ci <= ci + 1'b1;
                            end
                        end else begin
                            cj <= cj + 1'b1;
                        end
                    end else begin
                        ck <= ck + 1'b1;
                    end
                    if (mac_last) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                        ld_row   <= '0;
                        ld_col   <= '0;
                        ld_sel   <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Operand storage. A and B survive a compute and are only replaced by a new load.
    // NOTE: these arrays are deliberately reset; the engine must come out of reset
    // with defined operands and results, which costs a reset on every element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (load_fire) begin
            if (ld_sel) begin
                b_mem[ld_row][ld_col] <= in_data;
            end else begin
                a_mem[ld_row][ld_col] <= in_data;
            end
        end
    end

    // Result storage and sticky overflow; clear is honoured only outside COMPUTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    c_mem[r][c] <= '0;
                end
            end
            ovf <= 1'b0;
        end else if (c_clear) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    c_mem[r][c] <= '0;
                end
            end
            ovf <= 1'b0;
        end else if (state == ST_COMPUTE) begin
            if (mac_sum[CW]) begin
                ovf <= 1'b1;
            end
            if (mac_write) begin
                c_mem[ci][cj] <= mac_sum[CW-1:0];
            end
        end
    end

    // Registered read port; out-of-range indices read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_in_range ? c_mem[rd_row][rd_col] : '0;
        end
    end

endmodule

// File: doc/matrix_mac_engine.md
Name: matrix_mac_engine

Overview:
Parametrised NxN unsigned matrix multiply-accumulate engine and the successor to the fixed 2x2 accumulator datapath. It takes A and B element-serially over a valid/ready stream and computes C = A*B, or C += A*B in accumulate mode, using one sequential MAC. Results stay readable through a registered random-access read port, so the seven-segment display path can page through them. It sits between the switch/button front end (after debouncing) and the display converter.

Parameters:
N, 2, matrix dimension (N >= 2)
DW, 2, element width, unsigned
CW, 8, result/accumulator width; arithmetic wraps modulo 2^CW
AW, $clog2(N), row/column index width (derived; minimum 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element beat valid
in_ready  out  1  engine accepts element beat
in_data  in  DW  element; A row-major (N*N beats), then B row-major (N*N beats)
load_done  out  1  level; all 2*N*N beats received, engine in READY
start  in  1  single-cycle pulse; begins compute (READY only)
accumulate  in  1  sampled with start: 0 = overwrite C, 1 = C += A*B
clear  in  1  single-cycle pulse; zeroes C and ovf
busy  out  1  high throughout COMPUTE
done  out  1  one-cycle pulse when compute completes
ovf  out  1  sticky; any accumulate add carried out of CW bits
rd_row  in  AW  result row index
rd_col  in  AW  result column index
rd_data  out  CW  C[rd_row][rd_col], registered

Behaviour:
- Reset (async, rst_n=0): state LOAD; beat count, A, B, C, rd_data, ovf, done, busy, load_done all 0; in_ready=0 (registered). in_ready rises on the first clk edge after rst_n deasserts. Reset mid-compute aborts the compute and clears C.
- States: LOAD, READY, COMPUTE.
- LOAD: in_ready=1. A beat is accepted on in_valid&in_ready. Beats 0..N*N-1 write A[i][j], the rest write B, both row-major. On the edge that accepts beat 2*N*N-1: state->READY, in_ready->0, load_done->1 (visible next cycle). No back-pressure mid-load.
- READY: load_done=1. start -> COMPUTE and latches accumulate. clear in the same cycle as start: clear wins and start is ignored.
- COMPUTE: busy=1, load_done=0. Loop order is i, j, k with k innermost; one MAC per cycle, N^3 cycles total.
  - At k=0 the accumulator seeds with 0 (overwrite) or C[i][j] (accumulate).
  - Each cycle adds A[i][k]*B[k][j] (2*DW-bit product) into a CW+1-bit sum, truncated to CW bits.
  - C[i][j] is written on the k=N-1 cycle.
  - A carry into bit CW sets ovf (sticky).
- Completion: on the cycle after the final write, done pulses 1 cycle, busy->0, state->LOAD, beat count->0, in_ready->1. A and B are retained until overwritten. C is retained.
- Ignored inputs: start outside READY; clear during COMPUTE; in_valid outside LOAD.
- clear (LOAD/READY): all C and ovf go to 0 on the next edge. The load count and state are unaffected.
- Read port: rd_data <= C[rd_row][rd_col] every cycle, 1-cycle latency, valid in any state. During COMPUTE it may show mixed old/new values. An index >= N returns 0.
- No combinational path from any input to any output.

Test Plan:
- Reset/load, N=2 DW=2 CW=8: beats 3,2,1,2 (A) then 1,3,0,2 (B) -> load_done after the 8th beat. start, accumulate=0 -> busy for 8 cycles, done pulse. Reads (0,0)=3, (0,1)=13, (1,0)=1, (1,1)=7; ovf=0.
- Accumulate: after the above, load A=1,1,2,3 and B=3,1,3,2; start with accumulate=1 -> C=9,16,16,15. Repeat with accumulate=0 -> C=6,3,15,8.
- Overflow wrap: A and B all 3, clear, then 15 runs with accumulate=1 -> after run 14 every C=252 and ovf=0; after run 15 every C=14 and ovf=1. clear -> C=0, ovf=0.
- Protocol corners:
  - start pulsed in LOAD -> no busy.
  - in_valid during COMPUTE -> no beat accepted.
  - clear during COMPUTE -> ignored; final C is correct.
  - start+clear together in READY -> C=0 and no compute.
- Reset mid-compute: drop rst_n at compute cycle 4 -> rd_data=0, busy=0, in_ready=0 immediately. After release the engine is in LOAD and a fresh load/compute gives correct results.
- Parametric: N=3 DW=4 CW=12, A=identity, B=1..9 -> 27 busy cycles, C=B.
